// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM encoding, forwarding selects and the shadow-register records.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam int MD_LAT_DEF = 32;

    typedef struct packed {
        logic [4:0] wra;
        logic       we;
        logic       load;
        logic       md;
    } exe_sh_t;

    typedef struct packed {
        logic [4:0] wra;
        logic       we;
    } mem_sh_t;

    // r0 is hardwired to zero, so writes to it never produce a hazard.
    function automatic logic reg_hit(input logic [4:0] wra, input logic we,
                                     input logic [4:0] src);
        return we && (wra != 5'd0) && (wra == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// DEC/EXE decode inputs and stall/flush/forward controls between the
// datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    logic       dec_valid;
    logic [4:0] dec_ra1;
    logic [4:0] dec_ra2;
    logic       dec_use1;
    logic       dec_use2;
    logic [4:0] dec_wra;
    logic       dec_regWe;
    logic       dec_isLoad;
    logic       dec_isMulDiv;
    logic       exe_brTaken;

    logic       stall_if;
    logic       stall_dec;
    logic       flush_dec;
    logic       flush_exe;
    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic       md_done;

    modport master (
        output dec_valid, dec_ra1, dec_ra2, dec_use1, dec_use2, dec_wra,
               dec_regWe, dec_isLoad, dec_isMulDiv, exe_brTaken,
        input  stall_if, stall_dec, flush_dec, flush_exe, fwdA, fwdB, md_done
    );

    modport slave (
        input  dec_valid, dec_ra1, dec_ra2, dec_use1, dec_use2, dec_wra,
               dec_regWe, dec_isLoad, dec_isMulDiv, exe_brTaken,
        output stall_if, stall_dec, flush_dec, flush_exe, fwdA, fwdB, md_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_cmp.sv
// Single-operand comparator: picks the forwarding source for one DEC
// operand and flags a load-use hit against the EXE stage.
module hazard_fwd_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       use_i,
    input  logic [4:0] exe_wra_i,
    input  logic       exe_we_i,
    input  logic       exe_load_i,
    input  logic [4:0] mem_wra_i,
    input  logic       mem_we_i,
    output logic [1:0] fwd_o,
    output logic       ld_hit_o
);

    logic exe_hit;
    logic mem_hit;

    assign exe_hit  = use_i && reg_hit(exe_wra_i, exe_we_i, src_i);
    assign mem_hit  = use_i && reg_hit(mem_wra_i, mem_we_i, src_i);
    assign ld_hit_o = exe_hit && exe_load_i;

    // A load in EXE has no result yet, so it falls through to MEM.
    always_comb begin
        fwd_o = FWD_RF;
        if (exe_hit && !exe_load_i) begin
            fwd_o = FWD_EXE;
        end else if (mem_hit) begin
            fwd_o = FWD_MEM;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a DEC/EXE/MEM pipeline: operand forwarding,
// load-use stall, taken-branch flush and multi-cycle mul/div stall.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [5:0] CNT_LOAD = 6'(MD_LAT - 2);

    hz_state_e  state_q;
    logic [5:0] cnt_q;
    logic       md_done_q;

    exe_sh_t    exe_q, exe_d;
    mem_sh_t    mem_q, mem_d;

    logic       busy;
    logic       ld_hit_a, ld_hit_b;
    logic       load_use;
    logic       br_flush;
    logic       stall;
    logic       flush_exe;

    hazard_fwd_cmp u_cmp_a (
        .src_i      (hz.dec_ra1),
        .use_i      (hz.dec_use1),
        .exe_wra_i  (exe_q.wra),
        .exe_we_i   (exe_q.we),
        .exe_load_i (exe_q.load),
        .mem_wra_i  (mem_q.wra),
        .mem_we_i   (mem_q.we),
        .fwd_o      (hz.fwdA),
        .ld_hit_o   (ld_hit_a)
    );

    hazard_fwd_cmp u_cmp_b (
        .src_i      (hz.dec_ra2),
        .use_i      (hz.dec_use2),
        .exe_wra_i  (exe_q.wra),
        .exe_we_i   (exe_q.we),
        .exe_load_i (exe_q.load),
        .mem_wra_i  (mem_q.wra),
        .mem_we_i   (mem_q.we),
        .fwd_o      (hz.fwdB),
        .ld_hit_o   (ld_hit_b)
    );

    // exe_brTaken is a raw input; gating with rstn keeps outputs quiet in reset.
    assign busy      = (state_q == ST_MD_BUSY);
    assign br_flush  = rstn && !busy && hz.exe_brTaken;
    assign load_use  = !busy && hz.dec_valid && (ld_hit_a || ld_hit_b);
    assign stall     = busy || (load_use && !br_flush);
    assign flush_exe = busy || br_flush || load_use;

    assign hz.stall_if  = stall;
    assign hz.stall_dec = stall;
    assign hz.flush_dec = br_flush;
    assign hz.flush_exe = flush_exe;
    assign hz.md_done   = md_done_q;

    // While a mul/div is busy the EXE record is frozen and MEM sees bubbles.
    always_comb begin
        exe_d = exe_q;
        mem_d = '0;
        if (!busy) begin
            mem_d.wra = exe_q.wra;
            mem_d.we  = exe_q.we;
            exe_d     = '0;
            if (!flush_exe && hz.dec_valid) begin
                exe_d.wra  = hz.dec_wra;
                exe_d.we   = hz.dec_regWe;
                exe_d.load = hz.dec_isLoad;
                exe_d.md   = hz.dec_isMulDiv;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exe_q <= '0;
            mem_q <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
        end
    end

    // The first EXE cycle of a mul/div is spent in RUN, so the busy phase
    // lasts MD_LAT-1 cycles; md_done marks its last one (counter at 0).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            md_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (exe_q.md) begin
                        state_q   <= ST_MD_BUSY;
                        cnt_q     <= CNT_LOAD;
                        md_done_q <= (CNT_LOAD == 6'd0);
                    end
                end
                ST_MD_BUSY: begin
                    if (cnt_q == 6'd0) begin
                        state_q   <= ST_RUN;
                        md_done_q <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_q - 6'd1;
                        md_done_q <= (cnt_q == 6'd1);
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    md_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + randomized bench for pipe_hazard_ctrl, checked every cycle
// against a behavioural pipeline model kept in the bench.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int LAT = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MD_LAT(LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz)
    );

    // Model: the instruction records sitting in EXE and MEM, plus how many
    // busy (stalled) cycles the mul/div in EXE still has left.
    typedef struct {
        logic [4:0] wra;
        bit         we;
        bit         load;
        bit         md;
    } m_ins_t;

    m_ins_t m_exe, m_mem;
    int     m_busy_left;
    int     n_chk  = 0;
    int     n_pass = 0;
    int     n_fail = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input m_ins_t s, input logic [4:0] src);
        return s.we && (s.wra != 5'd0) && (s.wra == src);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src, input logic u);
        if (!u) return FWD_RF;
        if (hit(m_exe, src) && !m_exe.load) return FWD_EXE;
        if (hit(m_mem, src)) return FWD_MEM;
        return FWD_RF;
    endfunction

    task automatic exp_ctl(output bit busy, output bit br, output bit lu);
        busy = (m_busy_left > 0);
        br   = rstn && !busy && hz.exe_brTaken;
        lu   = !busy && hz.dec_valid && m_exe.load &&
               ((hz.dec_use1 && hit(m_exe, hz.dec_ra1)) ||
                (hz.dec_use2 && hit(m_exe, hz.dec_ra2)));
    endtask

    task automatic m_reset();
        m_exe       = '{default: 0};
        m_mem       = '{default: 0};
        m_busy_left = 0;
    endtask

    task automatic m_step();
        bit busy, br, lu;
        exp_ctl(busy, br, lu);
        if (busy) begin
            m_busy_left--;
            m_mem = '{default: 0};
        end else begin
            if (m_exe.md) m_busy_left = LAT - 1;
            m_mem      = m_exe;
            m_mem.load = 1'b0;
            m_mem.md   = 1'b0;
            if (!(br || lu) && hz.dec_valid)
                m_exe = '{hz.dec_wra, hz.dec_regWe, hz.dec_isLoad, hz.dec_isMulDiv};
            else
                m_exe = '{default: 0};
        end
    endtask

    task automatic check_all();
        bit busy, br, lu;
        exp_ctl(busy, br, lu);
        check("stall_if",  hz.stall_if,  busy || (lu && !br));
        check("stall_dec", hz.stall_dec, busy || (lu && !br));
        check("flush_dec", hz.flush_dec, br);
        check("flush_exe", hz.flush_exe, busy || br || lu);
        check("fwdA",      hz.fwdA,      exp_fwd(hz.dec_ra1, hz.dec_use1));
        check("fwdB",      hz.fwdB,      exp_fwd(hz.dec_ra2, hz.dec_use2));
        check("md_done",   hz.md_done,   busy && (m_busy_left == 1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall_if"},  hz.stall_if,  0);
        check({tag, "_stall_dec"}, hz.stall_dec, 0);
        check({tag, "_flush_dec"}, hz.flush_dec, 0);
        check({tag, "_flush_exe"}, hz.flush_exe, 0);
        check({tag, "_fwdA"},      hz.fwdA,      0);
        check({tag, "_fwdB"},      hz.fwdB,      0);
        check({tag, "_md_done"},   hz.md_done,   0);
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (rstn) m_step();
        else      m_reset();
        #1;
    endtask

    task automatic idle();
        hz.dec_valid    = 1'b0;
        hz.dec_ra1      = 5'd0;
        hz.dec_ra2      = 5'd0;
        hz.dec_use1     = 1'b0;
        hz.dec_use2     = 1'b0;
        hz.dec_wra      = 5'd0;
        hz.dec_regWe    = 1'b0;
        hz.dec_isLoad   = 1'b0;
        hz.dec_isMulDiv = 1'b0;
        hz.exe_brTaken  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_n, done_n, done_at;
        idle();
        rstn = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;
        cyc();

        // add r3 then a reader of r3: EXE forward, then MEM forward
        hz.dec_valid = 1'b1; hz.dec_wra = 5'd3; hz.dec_regWe = 1'b1;
        cyc();
        idle();
        hz.dec_valid = 1'b1; hz.dec_ra1 = 5'd3; hz.dec_use1 = 1'b1;
        #1 check("raw_exe_fwdA", hz.fwdA, FWD_EXE);
        cyc();
        #1 check("raw_mem_fwdA", hz.fwdA, FWD_MEM);
        idle();
        cyc();

        // lw r5 then a reader of r5 on operand B: one stall cycle, then MEM
        hz.dec_valid = 1'b1; hz.dec_wra = 5'd5; hz.dec_regWe = 1'b1; hz.dec_isLoad = 1'b1;
        cyc();
        idle();
        hz.dec_valid = 1'b1; hz.dec_ra2 = 5'd5; hz.dec_use2 = 1'b1;
        #1;
        check("lu_stall_if",  hz.stall_if,  1);
        check("lu_stall_dec", hz.stall_dec, 1);
        check("lu_flush_exe", hz.flush_exe, 1);
        check("lu_flush_dec", hz.flush_dec, 0);
        cyc();
        #1;
        check("lu_after_stall_if", hz.stall_if, 0);
        check("lu_after_fwdB",     hz.fwdB,     FWD_MEM);
        idle();
        cyc();

        // write r0 then read r0: no forwarding, no stall
        hz.dec_valid = 1'b1; hz.dec_wra = 5'd0; hz.dec_regWe = 1'b1; hz.dec_isLoad = 1'b1;
        cyc();
        idle();
        hz.dec_valid = 1'b1; hz.dec_use1 = 1'b1; hz.dec_use2 = 1'b1;
        #1;
        check("r0_fwdA",  hz.fwdA,     FWD_RF);
        check("r0_fwdB",  hz.fwdB,     FWD_RF);
        check("r0_stall", hz.stall_if, 0);
        cyc();
        #1 check("r0_mem_fwdA", hz.fwdA, FWD_RF);
        idle();
        cyc();

        // branch together with a load-use hazard: branch wins
        hz.dec_valid = 1'b1; hz.dec_wra = 5'd7; hz.dec_regWe = 1'b1; hz.dec_isLoad = 1'b1;
        cyc();
        idle();
        hz.dec_valid = 1'b1; hz.dec_ra1 = 5'd7; hz.dec_use1 = 1'b1; hz.exe_brTaken = 1'b1;
        #1;
        check("br_lu_flush_dec", hz.flush_dec, 1);
        check("br_lu_flush_exe", hz.flush_exe, 1);
        check("br_lu_stall_if",  hz.stall_if,  0);
        check("br_lu_stall_dec", hz.stall_dec, 0);
        cyc();
        idle();
        cyc();

        // mul: 31 stall cycles, md_done once on EXE cycle 32, branch ignored
        hz.dec_valid = 1'b1; hz.dec_wra = 5'd9; hz.dec_regWe = 1'b1; hz.dec_isMulDiv = 1'b1;
        cyc();
        idle();
        stall_n = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            hz.exe_brTaken = (i == 5);
            #1;
            stall_n += int'(hz.stall_if);
            if (hz.md_done) begin
                done_n++;
                done_at = i;
            end
            if (i == 5) check("md_br_ignored", hz.flush_dec, 0);
            cyc();
        end
        idle();
        #1;
        check("md_stall_cycles", 8'(stall_n), 8'd31);
        check("md_done_count",   8'(done_n),  8'd1);
        check("md_done_cycle",   8'(done_at), 8'd31);
        check("md_run_resumed",  hz.stall_if, 0);
        cyc();

        // reset 10 cycles into a mul: outputs drop at once, no md_done later
        hz.dec_valid = 1'b1; hz.dec_wra = 5'd4; hz.dec_regWe = 1'b1; hz.dec_isMulDiv = 1'b1;
        cyc();
        idle();
        repeat (10) cyc();
        check("md_busy_before_rst", hz.stall_if, 1);
        #2;
        rstn = 1'b0;
        hz.exe_brTaken = 1'b1;
        m_reset();
        #1 check_zero("async_rst");
        repeat (2) cyc();
        rstn = 1'b1;
        hz.exe_brTaken = 1'b0;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (hz.md_done) done_n++;
            cyc();
        end
        check("rst_no_md_done", 8'(done_n), 8'd0);
        check("rst_run_state",  hz.stall_if, 0);

        // randomized traffic over a small register set to provoke hazards
        for (int k = 0; k < 600; k++) begin
            hz.dec_valid    = ($urandom_range(0, 3) != 0);
            hz.dec_ra1      = 5'($urandom_range(0, 3));
            hz.dec_ra2      = 5'($urandom_range(0, 3));
            hz.dec_use1     = 1'($urandom_range(0, 1));
            hz.dec_use2     = 1'($urandom_range(0, 1));
            hz.dec_wra      = 5'($urandom_range(0, 3));
            hz.dec_regWe    = ($urandom_range(0, 3) != 0);
            hz.dec_isLoad   = ($urandom_range(0, 2) == 0);
            hz.dec_isMulDiv = ($urandom_range(0, 49) == 0);
            hz.exe_brTaken  = ($urandom_range(0, 7) == 0);
            cyc();
        end
        idle();
        repeat (40) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
